// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one instruction memory between a fetch port and a loader port,
// with round-robin arbitration, bounded loader lock bursts and range checking.
module imem_arbiter #(
    parameter int DEPTH     = 256,
    parameter int MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    output logic        f_err,
    input  logic        l_req,
    input  logic        l_we,
    input  logic        l_lock,
    input  logic [15:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [31:0] l_rdata,
    output logic        l_err,
    output logic        m_write,
    output logic [15:0] m_addr,
    output logic [31:0] m_datain,
    input  logic [31:0] m_dataout
);
    localparam int CW = $clog2(MAX_BURST + 1);
    typedef enum logic [1:0] {IDLE, RESP_F, RESP_L} state_t;
    state_t         state_q, state_d;
    logic           last_l_q, last_l_d;
    logic           locked_q, locked_d;
    logic [CW-1:0]  lock_cnt_q, lock_cnt_d;
    logic           resp_err_q, resp_err_d;
    logic           resp_write_q, resp_write_d;
    logic           f_oor, l_oor, at_max, l_win;
    always_comb begin
        f_oor        = 32'(f_addr) >= 32'(DEPTH);
        l_oor        = 32'(l_addr) >= 32'(DEPTH);
        at_max       = lock_cnt_q == CW'(MAX_BURST);
        // loader wins when alone, when its lock still holds, or when it is fetch's turn to wait
        l_win        = l_req && (!f_req || (locked_q && !at_max) || !last_l_q);
        l_gnt        = !reset && l_win;
        f_gnt        = !reset && f_req && !l_win;
        m_write      = l_gnt && l_we && !l_oor;
        m_addr       = (f_gnt && !f_oor) ? f_addr : (l_gnt && !l_oor) ? l_addr : '0;
        m_datain     = m_write ? l_wdata : '0;
        state_d      = f_gnt ? RESP_F : l_gnt ? RESP_L : IDLE;
        last_l_d     = f_gnt ? 1'b0 : l_gnt ? 1'b1 : last_l_q;
        locked_d     = l_gnt && l_lock;
        resp_err_d   = f_gnt ? f_oor : (l_gnt && l_oor);
        resp_write_d = l_gnt && l_we;
        lock_cnt_d   = (f_gnt || (l_gnt && !l_lock)) ? '0 :
                       (l_gnt && f_req && !at_max) ? lock_cnt_q + 1'b1 : lock_cnt_q;
        f_rvalid     = state_q == RESP_F;
        f_err        = f_rvalid && resp_err_q;
        f_rdata      = (f_rvalid && !resp_err_q) ? m_dataout : '0;
        l_rvalid     = state_q == RESP_L;
        l_err        = l_rvalid && resp_err_q;
        l_rdata      = (l_rvalid && !resp_err_q && !resp_write_q) ? m_dataout : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_l_q     <= 1'b1;
            locked_q     <= 1'b0;
            lock_cnt_q   <= '0;
            resp_err_q   <= 1'b0;
            resp_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_l_q     <= last_l_d;
            locked_q     <= locked_d;
            lock_cnt_q   <= lock_cnt_d;
            resp_err_q   <= resp_err_d;
            resp_write_q <= resp_write_d;
        end
    end
endmodule
